// File: rtl/ber_ctrl_pkg.sv
// Shared types and defaults for the convolutional-link BER controller.
package ber_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ber_state_t;

    // {valid, src_bit} pair carried through the decoder-latency delay line
    typedef struct packed {
        logic vld;
        logic bit_val;
    } src_tap_t;

    localparam int ROM_LAT       = 1;
    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_FRAME_LEN = 2048;
    localparam int DEF_DEC_LAT   = 16;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/bit_delay.sv
// Fixed-depth shift register with synchronous clear.
module bit_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/conv_link_ber_ctrl.sv
// Run sequencer for the (2,1) conv-code link: sweeps ROM addresses for N frames,
// then counts decoder bit errors against a latency-matched copy of the source.
module conv_link_ber_ctrl
    import ber_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int DEC_LAT   = DEF_DEC_LAT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk_sig,
    input  logic              reset_sig,
    input  logic              start_sig,
    input  logic [7:0]        frames_sig,
    input  logic              noise_cfg_sig,
    input  logic              src_bit_sig,
    input  logic              dec_bit_sig,
    output logic [ADDR_W-1:0] address_sig,
    output logic              enc_en_sig,
    output logic              noise_en_sig,
    output logic              busy_sig,
    output logic              done_sig,
    output logic [CNT_W-1:0]  err_cnt_sig,
    output logic [CNT_W-1:0]  bit_cnt_sig,
    output logic              err_sat_sig
);

    localparam int FL_W = $clog2(DEC_LAT + 1);
    localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(DEC_LAT);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(FRAME_LEN - 1);

    ber_state_t        state, state_nxt;
    logic [7:0]        frm_left;
    logic              noise_lat, noise_nxt;
    logic [FL_W-1:0]   flush_cnt;
    logic              start_acc, addr_end, last_addr;
    logic              enc_en_d, busy_d, noise_en_d, done_d;
    logic [ROM_LAT-1:0] en_pipe;
    src_tap_t          src_in, src_dly;
    logic [CNT_W-1:0]  err_nxt, bit_nxt;

    assign start_acc = (state == IDLE) && start_sig;
    assign addr_end  = (address_sig == ADDR_LAST);
    assign last_addr = addr_end && (frm_left == 8'd1);
    assign noise_nxt = start_acc ? noise_cfg_sig : noise_lat;

    always_ff @(posedge clk_sig) begin
        if (reset_sig) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_sig) state_nxt = RUN;
            RUN:     if (last_addr) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded from the next state so the registered outputs line up with it
    always_comb begin
        enc_en_d   = (state_nxt == RUN);
        busy_d     = (state_nxt == RUN) || (state_nxt == FLUSH);
        noise_en_d = busy_d && noise_nxt;
        done_d     = (state_nxt == DONE);
    end

    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            address_sig  <= '0;
            frm_left     <= '0;
            noise_lat    <= 1'b0;
            flush_cnt    <= '0;
            enc_en_sig   <= 1'b0;
            noise_en_sig <= 1'b0;
            busy_sig     <= 1'b0;
            done_sig     <= 1'b0;
        end else begin
            enc_en_sig   <= enc_en_d;
            noise_en_sig <= noise_en_d;
            busy_sig     <= busy_d;
            done_sig     <= done_d;
            noise_lat    <= noise_nxt;
            if (start_acc)
                frm_left <= (frames_sig == 8'd0) ? 8'd1 : frames_sig;
            else if (state == RUN && addr_end)
                frm_left <= frm_left - 8'd1;
            address_sig <= (state == RUN && !addr_end) ? address_sig + 1'b1 : '0;
            flush_cnt   <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
        end
    end

    // enc_en aged by the ROM read latency marks which src_bit samples are live
    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            en_pipe <= '0;
        end else begin
            en_pipe[0] <= enc_en_sig;
            for (int i = 1; i < ROM_LAT; i++) en_pipe[i] <= en_pipe[i-1];
        end
    end

    assign src_in.vld     = en_pipe[ROM_LAT-1];
    assign src_in.bit_val = src_bit_sig;

    bit_delay #(.DEPTH(DEC_LAT), .WIDTH(2)) u_dly (
        .clk_sig   (clk_sig),
        .reset_sig (reset_sig),
        .din       (src_in),
        .dout      (src_dly)
    );

    always_comb begin
        err_nxt = err_cnt_sig;
        bit_nxt = bit_cnt_sig;
        if (start_acc) begin
            err_nxt = '0;
            bit_nxt = '0;
        end else if (src_dly.vld) begin
            if (bit_cnt_sig != '1) bit_nxt = bit_cnt_sig + 1'b1;
            if (dec_bit_sig != src_dly.bit_val && err_cnt_sig != '1)
                err_nxt = err_cnt_sig + 1'b1;
        end
    end

    always_ff @(posedge clk_sig) begin
        if (reset_sig) begin
            err_cnt_sig <= '0;
            bit_cnt_sig <= '0;
            err_sat_sig <= 1'b0;
        end else begin
            err_cnt_sig <= err_nxt;
            bit_cnt_sig <= bit_nxt;
            if (start_acc)           err_sat_sig <= 1'b0;
            else if (err_nxt == '1)  err_sat_sig <= 1'b1;
        end
    end

endmodule

// File: doc/conv_link_ber_ctrl.md
# conv_link_ber_ctrl

Test sequencer and bit-error-rate monitor for the (2,1) convolutional-code link. It drives the source ROM address and the encoder/noise enables for a programmed number of frames. It compares the Viterbi decoder output against a latency-matched copy of the source bit and reports error and bit totals. It runs on the 10 MHz link clock, alongside the address counter it replaces.

## Interface
Parameters:
- ADDR_W, 11, ROM address width
- FRAME_LEN, 2048, bits per frame (addresses 0..FRAME_LEN-1); must be ≥ 2 and ≤ 2^ADDR_W
- DEC_LAT, 16, cycles from ROM q to matching decoder output; must be ≥ 1
- CNT_W, 16, width of the error and bit counters

Ports:
- clk_sig, in, 1, link clock (10 MHz)
- reset_sig, in, 1, synchronous, active-high
- start_sig, in, 1, run request; sampled only in IDLE
- frames_sig, in, 8, number of frames; latched on start; 0 is treated as 1
- noise_cfg_sig, in, 1, noise injection request; latched on start
- src_bit_sig, in, 1, ROM q (1-cycle ROM latency)
- dec_bit_sig, in, 1, decoder output
- address_sig, out, ADDR_W, ROM address
- enc_en_sig, out, 1, encoder/source active
- noise_en_sig, out, 1, noise injector enable
- busy_sig, out, 1, run in progress
- done_sig, out, 1, one-cycle completion pulse
- err_cnt_sig, out, CNT_W, bit errors
- bit_cnt_sig, out, CNT_W, compared bits
- err_sat_sig, out, 1, error counter saturated

## Operation
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and the delay line is cleared.
- FSM states are IDLE, RUN, FLUSH and DONE.
- IDLE → RUN on start_sig. The transition latches frames (0→1) and noise_cfg, and clears err_cnt, bit_cnt and err_sat.
- RUN:
  - address_sig increments by 1 per cycle starting at 0.
  - At FRAME_LEN-1 the address wraps to 0 and the frame counter decrements.
  - After the last address of the last frame, the FSM enters FLUSH.
- FLUSH lasts exactly 1+DEC_LAT cycles, then the FSM goes to DONE.
- DONE lasts one cycle, then the FSM returns to IDLE.
- enc_en_sig is 1 exactly in RUN.
- busy_sig is 1 in RUN and FLUSH.
- noise_en_sig equals the latched noise_cfg while in RUN or FLUSH, and is 0 otherwise.
- done_sig is 1 only in DONE.
- address_sig returns to 0 in IDLE.
- Compare path:
  - src_valid is enc_en delayed 1 cycle (ROM latency).
  - The pair (src_valid, src_bit) is delayed DEC_LAT more cycles.
  - When the delayed valid is 1: bit_cnt increments, and err_cnt increments if dec_bit_sig ≠ delayed src bit.
- Both counters saturate at 2^CNT_W-1. err_sat_sig is set when err_cnt reaches all-ones and stays set until the next start.
- Counters and err_sat hold their values in IDLE and DONE until the next accepted start.
- Boundary rules:
  - start_sig is ignored in RUN, FLUSH and DONE.
  - reset_sig asserted in any state returns to IDLE the next cycle with all outputs 0; no done pulse is issued.
  - frames_sig and noise_cfg_sig changing mid-run have no effect.

## Timing
- With start accepted at cycle 0:
  - RUN covers cycles 1..F·FRAME_LEN, with address k of frame j at cycle 1+j·FRAME_LEN+k.
  - The first compare occurs at cycle 2+DEC_LAT.
  - FLUSH covers the next 1+DEC_LAT cycles.
  - done_sig is high at cycle F·FRAME_LEN+DEC_LAT+2.
- The final compare lands in the last FLUSH cycle, so the counters are final when done_sig is high.
- A start_sig high in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.

## Structure
- Shared package ber_ctrl_pkg holds:
  - the FSM state typedef (IDLE, RUN, FLUSH, DONE);
  - ROM_LAT = 1;
  - the default values of ADDR_W, FRAME_LEN, DEC_LAT and CNT_W.
- Sub-module bit_delay (parameters DEPTH and WIDTH, synchronous reset, shift register) carries {valid, src_bit}; it is instantiated with DEPTH=DEC_LAT and WIDTH=2.

## Test plan
Bench parameters: FRAME_LEN=16, DEC_LAT=4, CNT_W=16 unless stated.
- Perfect loop (dec_bit = src_bit delayed by DEC_LAT), frames=1, start at cycle 0 → RUN cycles 1..16, FLUSH 17..21, done_sig high only at cycle 22; err_cnt=0, bit_cnt=16.
- Same loop with dec_bit inverted on the 3rd, 7th and 16th compares → err_cnt=3, bit_cnt=16, err_sat=0.
- frames=2 with noise_cfg=1 → address wraps 15→0 exactly once; noise_en high for cycles 1..37; done at cycle 38; bit_cnt=32. Rerun with frames=0 → behaves as frames=1 (done at cycle 22).
- start_sig pulsed at cycles 5 and 22 during a run → no restart and no counter clear. start_sig at cycle 23 → new run begins, with counters cleared at cycle 24.
- reset_sig at cycle 8 of a run → at cycle 9 FSM is IDLE, address=0, busy=0, counters=0; done_sig never asserts.
- CNT_W=4, dec_bit always wrong, frames=2 → err_cnt=15, bit_cnt=15, err_sat=1 at done; both counters hold until the next start.
